// File: rtl/sub_pipe.sv
// Pipelined subtractor with valid/ready handshaking, borrow/overflow flags and a sticky overflow bit.
// Define SUB_PIPE_SAT_EN to saturate diff on out-of-range results instead of wrapping.
module sub_pipe #(
  parameter int DATAWIDTH = 8,
  parameter int STAGES    = 2,
  parameter int SIGNED    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] diff,
  output logic                 borrow,
  output logic                 ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 ovf_sticky,
  input  logic                 clr_sticky
);

  logic [DATAWIDTH:0]   ext;
  logic [DATAWIDTH-1:0] raw;
  logic [DATAWIDTH-1:0] res;
  logic                 cborrow;
  logic                 csovf;
  logic                 covf;

  logic [STAGES-1:0]    vld;
  logic [STAGES-1:0]    rdy;
  logic [STAGES-1:0]    sborrow;
  logic [STAGES-1:0]    sovf;
  logic [DATAWIDTH-1:0] sdiff [STAGES];

  assign ext = {1'b0, a} - {1'b0, b};

  // Flags always describe the unclamped difference, even when diff saturates.
  always_comb begin
    raw     = ext[DATAWIDTH-1:0];
    cborrow = ext[DATAWIDTH];
    csovf   = (a[DATAWIDTH-1] != b[DATAWIDTH-1]) && (raw[DATAWIDTH-1] != a[DATAWIDTH-1]);
    covf    = (SIGNED != 0) ? csovf : cborrow;
    res     = raw;
`ifdef SUB_PIPE_SAT_EN
    if (SIGNED == 0) begin
      if (cborrow) res = '0;
    end else if (csovf) begin
      res = a[DATAWIDTH-1] ? {1'b1, {(DATAWIDTH-1){1'b0}}} : {1'b0, {(DATAWIDTH-1){1'b1}}};
    end
`endif
  end

  // A slot can take new data unless it and every slot downstream are full with the output stalled.
  always_comb begin
    logic full;
    full = 1'b1;
    rdy  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full   = full & vld[k];
      rdy[k] = !full || out_ready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld     <= '0;
      sborrow <= '0;
      sovf    <= '0;
      for (int k = 0; k < STAGES; k++) sdiff[k] <= '0;
    end else begin
      if (rdy[0]) begin
        vld[0] <= in_valid;
        if (in_valid) begin
          sdiff[0]   <= res;
          sborrow[0] <= cborrow;
          sovf[0]    <= covf;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) begin
            sdiff[k]   <= sdiff[k-1];
            sborrow[k] <= sborrow[k-1];
            sovf[k]    <= sovf[k-1];
          end
        end
      end
    end
  end

  // Setting wins over a simultaneous clear so an overflow is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (vld[STAGES-1] && out_ready && sovf[STAGES-1]) begin
      ovf_sticky <= 1'b1;
    end else if (clr_sticky) begin
      ovf_sticky <= 1'b0;
    end
  end

  assign in_ready  = rst_n & rdy[0];
  assign out_valid = vld[STAGES-1];
  assign diff      = sdiff[STAGES-1];
  assign borrow    = sborrow[STAGES-1];
  assign ovf       = sovf[STAGES-1];

endmodule

// File: tb/tb_sub_pipe.sv
// Randomized self-checking bench for sub_pipe: an unsigned and a signed instance run side by side
// against a queue-based reference model, plus directed cases for latency, stall, reset and sticky behaviour.
module tb_sub_pipe;

  localparam int W  = 8;
  localparam int ST = 2;

`ifdef SUB_PIPE_SAT_EN
  localparam logic [7:0] EXP_U_NEG = 8'h00;
  localparam logic [7:0] EXP_S_OVF = 8'h80;
`else
  localparam logic [7:0] EXP_U_NEG = 8'hFE;
  localparam logic [7:0] EXP_S_OVF = 8'h7F;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         clr_sticky = 1'b0;

  logic         in_ready, borrow, ovf, out_valid, ovf_sticky;
  logic [W-1:0] diff;
  logic         s_in_ready, s_borrow, s_ovf, s_out_valid, s_ovf_sticky;
  logic [W-1:0] s_diff;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] du;
    logic       bu;
    logic       ou;
    logic [7:0] ds;
    logic       bs;
    logic       os;
    int         t;
  } ent_t;

  ent_t q[$];
  logic stU = 1'b0;
  logic stS = 1'b0;

  sub_pipe #(.DATAWIDTH(W), .STAGES(ST), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .diff(diff), .borrow(borrow), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready),
    .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
  );

  sub_pipe #(.DATAWIDTH(W), .STAGES(ST), .SIGNED(1)) u_sdut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(s_in_ready),
    .diff(s_diff), .borrow(s_borrow), .ovf(s_ovf), .out_valid(s_out_valid), .out_ready(out_ready),
    .ovf_sticky(s_ovf_sticky), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic ent_t refModel(input logic [7:0] x, input logic [7:0] y, input int t);
    ent_t e;
    int   du, ds, sx, sy;
    du = int'(x) - int'(y);
    e.bu = (du < 0);
    e.ou = e.bu;
`ifdef SUB_PIPE_SAT_EN
    e.du = (du < 0) ? 8'd0 : 8'(du);
`else
    e.du = 8'((du + 256) % 256);
`endif
    sx = (x > 127) ? int'(x) - 256 : int'(x);
    sy = (y > 127) ? int'(y) - 256 : int'(y);
    ds = sx - sy;
    e.bs = e.bu;
    e.os = (ds > 127) || (ds < -128);
`ifdef SUB_PIPE_SAT_EN
    if (ds > 127) e.ds = 8'h7F;
    else if (ds < -128) e.ds = 8'h80;
    else e.ds = 8'((ds + 256) % 256);
`else
    e.ds = 8'((ds + 256) % 256);
`endif
    e.t = t;
    return e;
  endfunction

  // Scoreboard: handshake expectations, ordering, latency and sticky flag, sampled mid-cycle.
  always @(negedge clk) begin
    logic expRdy, expOv;
    ent_t h;
    if (!rst_n) begin
      q.delete();
      stU = 1'b0;
      stS = 1'b0;
      checkOutput("rst_in_ready", in_ready, 1'b0);
      checkOutput("rst_out_valid", out_valid, 1'b0);
    end else begin
      expRdy = (q.size() < ST) || out_ready;
      expOv  = (q.size() > 0) && (cyc - q[0].t >= ST - 1);
      checkOutput("in_ready", in_ready, expRdy);
      checkOutput("s_in_ready", s_in_ready, expRdy);
      checkOutput("out_valid", out_valid, expOv);
      checkOutput("s_out_valid", s_out_valid, expOv);
      checkOutput("ovf_sticky", ovf_sticky, stU);
      checkOutput("s_ovf_sticky", s_ovf_sticky, stS);
      if (expOv) begin
        h = q[0];
        checkOutput("diff", diff, h.du);
        checkOutput("borrow", borrow, h.bu);
        checkOutput("ovf", ovf, h.ou);
        checkOutput("s_diff", s_diff, h.ds);
        checkOutput("s_borrow", s_borrow, h.bs);
        checkOutput("s_ovf", s_ovf, h.os);
      end
      if (expOv && out_ready) begin
        h = q.pop_front();
        stU = h.ou ? 1'b1 : (clr_sticky ? 1'b0 : stU);
        stS = h.os ? 1'b1 : (clr_sticky ? 1'b0 : stS);
      end else if (clr_sticky) begin
        stU = 1'b0;
        stS = 1'b0;
      end
      if (in_valid && expRdy) q.push_back(refModel(a, b, cyc + 1));
    end
  end

  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input logic vv,
                               input logic vor, input logic vclr);
    a          = va;
    b          = vb;
    in_valid   = vv;
    out_ready  = vor;
    clr_sticky = vclr;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] va [4] = '{8'h20, 8'h30, 8'h40, 8'h50};
  logic [7:0] vb [4] = '{8'h10, 8'h05, 8'h50, 8'h01};

  initial begin
    int  idx;
    logic acc;

    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_in_ready", in_ready, 1'b0);
    checkOutput("reset_diff", diff, 8'h00);
    checkOutput("reset_borrow", borrow, 1'b0);
    checkOutput("reset_sticky", ovf_sticky, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // 5 - 3 with exact two-cycle latency.
    applyStimulus(8'h05, 8'h03, 1'b1, 1'b1, 1'b0);
    checkOutput("lat_early", out_valid, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("lat_valid", out_valid, 1'b1);
    checkOutput("lat_diff", diff, 8'h02);
    checkOutput("lat_borrow", borrow, 1'b0);

    // 3 - 5 unsigned underflow, sticky after transfer.
    applyStimulus(8'h03, 8'h05, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("uflow_diff", diff, EXP_U_NEG);
    checkOutput("uflow_borrow", borrow, 1'b1);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("uflow_sticky", ovf_sticky, 1'b1);

    // Signed 0x80 - 0x01 overflows.
    applyStimulus(8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("sovf_ovf", s_ovf, 1'b1);
    checkOutput("sovf_diff", s_diff, EXP_S_OVF);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);

    // Offer four pairs into a stalled pipe.
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      acc = in_ready;
      applyStimulus(va[idx], vb[idx], 1'b1, 1'b0, 1'b0);
      if (acc) idx++;
    end
    checkOutput("stall_accepted", idx, 2);
    checkOutput("stall_in_ready", in_ready, 1'b0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(va[idx], vb[idx], 1'b1, 1'b0, 1'b0);
      checkOutput("stall_hold", diff, 8'h10);
    end
    for (int c = 0; c < 10; c++) begin
      in_valid  = (idx < 4);
      a         = va[idx % 4];
      b         = vb[idx % 4];
      out_ready = 1'b1;
      #1;
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    checkOutput("stall_all_in", idx, 4);

    // Reset with two results in flight.
    applyStimulus(8'h11, 8'h01, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h22, 8'h02, 1'b1, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid, 1'b0);
    checkOutput("midrst_s_out_valid", s_out_valid, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // Clear coinciding with an overflowing output transfer.
    applyStimulus(8'h03, 8'h05, 1'b1, 1'b1, 1'b1);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("sticky_setwins", ovf_sticky, 1'b1);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("sticky_cleared", ovf_sticky, 1'b0);

    for (int c = 0; c < 1500; c++) begin
      applyStimulus(8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    end

    in_valid = 1'b0;
    for (int c = 0; c < 20 && q.size() != 0; c++) applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("drain_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_pipe.md
SUB_PIPE -- requirements
Module: SUB_PIPE

Interface
REQ-001 Parameter DATAWIDTH, default 8, SHALL set the operand and result width in bits; legal range is 2..64.
REQ-002 Parameter STAGES, default 2, SHALL set the pipeline depth and latency in cycles; legal range is 1..4.
REQ-003 Parameter SIGNED, default 0, SHALL select two's-complement operands when 1 and unsigned operands when 0.
REQ-004 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 a  input  DATAWIDTH  SHALL be the minuend.
REQ-007 b  input  DATAWIDTH  SHALL be the subtrahend.
REQ-008 in_valid  input  1  SHALL mark a and b as a valid operand pair.
REQ-009 in_ready  output  1  SHALL indicate that SUB_PIPE can accept an operand pair this cycle.
REQ-010 diff  output  DATAWIDTH  SHALL carry the result of a - b.
REQ-011 borrow  output  1  SHALL be the unsigned borrow, meaning a < b as unsigned values.
REQ-012 ovf  output  1  SHALL be the signed overflow flag when SIGNED=1 and the same value as borrow when SIGNED=0.
REQ-013 out_valid  output  1  SHALL mark diff, borrow and ovf as valid.
REQ-014 out_ready  input  1  SHALL indicate that the consumer accepts the result this cycle.
REQ-015 ovf_sticky  output  1  SHALL be the accumulated overflow status.
REQ-016 clr_sticky  input  1  SHALL be the synchronous clear for ovf_sticky.

Function
REQ-017 An input transfer SHALL occur on a rising edge when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-018 Arithmetic SHALL be evaluated on input transfer using DATAWIDTH+1 bit precision: borrow is bit DATAWIDTH of {0,a}-{0,b}, and signed overflow is (a[MSB] != b[MSB]) and (diff[MSB] != a[MSB]).
REQ-019 The pipeline SHALL hold STAGES registered slots, each slot containing a valid bit plus diff, borrow and ovf; slot 1 is loaded on input transfer and slot STAGES drives the outputs.
REQ-020 Slot k SHALL advance when slot k+1 is empty or advancing; slot STAGES SHALL advance on output transfer; bubbles SHALL collapse.
REQ-021 in_ready SHALL be 1 when slot 1 is empty or advancing, with a combinational path from out_ready permitted.
REQ-022 With no stall, the latency from input transfer to out_valid SHALL be exactly STAGES cycles, and throughput SHALL be one result per cycle.
REQ-023 While out_valid=1 and out_ready=0, diff, borrow and ovf SHALL be held stable.
REQ-024 Results SHALL leave in acceptance order with no loss or duplication; at most STAGES results SHALL be in flight.
REQ-025 ovf_sticky SHALL set on the cycle a result with ovf=1 is transferred out; clr_sticky SHALL clear it, and a simultaneous set and clear SHALL leave it at 1 (set wins).
REQ-026 Operand values when in_valid=0 SHALL have no effect on state.

Reset
REQ-027 Reset assertion SHALL immediately clear all slot valid bits, out_valid, diff, borrow, ovf and ovf_sticky to 0, independent of Clk.
REQ-028 Reset SHALL discard in-flight results mid-operation; in_ready SHALL be 0 during reset and 1 on the first cycle after deassertion.

Configuration
REQ-029 The macro SUB_PIPE_SAT_EN SHALL select the out-of-range behaviour of diff.
REQ-030 Without SUB_PIPE_SAT_EN, diff SHALL wrap modulo 2^DATAWIDTH.
REQ-031 With SUB_PIPE_SAT_EN, diff SHALL clamp to 0 on underflow when SIGNED=0.
REQ-032 With SUB_PIPE_SAT_EN and SIGNED=1, diff SHALL clamp to the signed minimum or maximum on overflow; borrow and ovf SHALL still report the unclamped condition.

Verification
REQ-033 The bench SHALL check DATAWIDTH=8, STAGES=2, SIGNED=0: a=0x05, b=0x03 -> diff=0x02, borrow=0, out_valid exactly 2 cycles after the input transfer.
REQ-034 The bench SHALL check a=0x03, b=0x05 (unsigned) -> without SAT: diff=0xFE, borrow=1; with SAT: diff=0x00, borrow=1; ovf_sticky=1 after the output transfer.
REQ-035 The bench SHALL check SIGNED=1: a=0x80, b=0x01 -> ovf=1; without SAT diff=0x7F; with SAT diff=0x80.
REQ-036 The bench SHALL check STAGES=2 with out_ready=0, offering 4 pairs -> exactly 2 accepted, then in_ready=0; after out_ready=1, all 4 results emerge in order with diff held stable while stalled.
REQ-037 The bench SHALL check reset asserted with 2 results in flight -> out_valid=0 immediately, and no stale result appears after reset release.
REQ-038 The bench SHALL check clr_sticky=1 on the same cycle as an overflowing output transfer -> ovf_sticky=1; clr_sticky alone on the next cycle -> ovf_sticky=0.
